// File: rtl/expression_pipe_eval.sv
`default_nettype none
// ============================================================================
// expression_pipe_eval
// Multi-lane signed/unsigned opcode evaluator behind a PIPE-stage valid/ready pipeline.
// Rev 1.0
// ============================================================================
module expression_pipe_eval #(
    parameter int               W           = 6,
    parameter int               LANES       = 6,
    parameter logic [LANES-1:0] SIGNED_MASK = 6'b000111,
    parameter int               PIPE        = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LANES*W-1:0]   a,
    input  logic [LANES*W-1:0]   b,
    input  logic [LANES*3-1:0]   op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*W-1:0]   y,
    output logic [LANES-1:0]     ovf,
    output logic [15:0]          count
);

    localparam int c_iw = 2 * W;

    // Returns {ovf, result} for one lane.
    function automatic logic [W:0] eval_lane(
        input logic [W-1:0] fa,
        input logic [W-1:0] fb,
        input logic [2:0]   fop,
        input logic         fs
    );
        logic [W-1:0]    r;
        logic            o;
        logic [W:0]      ext_sum;
        logic [c_iw-1:0] wide;
        logic [c_iw-1:0] ax;
        logic [c_iw-1:0] bx;
        logic            shift_big;
        logic            lt;
        r         = '0;
        o         = 1'b0;
        ext_sum   = '0;
        wide      = '0;
        ax        = fs ? {{W{fa[W-1]}}, fa} : {{W{1'b0}}, fa};
        bx        = fs ? {{W{fb[W-1]}}, fb} : {{W{1'b0}}, fb};
        shift_big = (int'(fb) >= W);
        lt        = fs ? ($signed(fa) < $signed(fb)) : (fa < fb);
        case (fop)
            3'd0: begin
                ext_sum = {1'b0, fa} + {1'b0, fb};
                r = ext_sum[W-1:0];
                o = fs ? ((fa[W-1] == fb[W-1]) && (r[W-1] != fa[W-1])) : ext_sum[W];
            end
            3'd1: begin
                ext_sum = {1'b0, fa} - {1'b0, fb};
                r = ext_sum[W-1:0];
                o = fs ? ((fa[W-1] != fb[W-1]) && (r[W-1] != fa[W-1])) : ext_sum[W];
            end
            3'd2: begin
                // Out-of-range shift amounts give zero with no overflow flag.
                if (!shift_big) begin
                    wide = {{W{1'b0}}, fa} << fb;
                    r = wide[W-1:0];
                    o = fs ? (r[W-1] != fa[W-1]) : (|wide[c_iw-1:W]);
                end
            end
            3'd3: begin
                if (shift_big) begin
                    r = fs ? {W{fa[W-1]}} : '0;
                end else begin
                    wide = ax >> fb;
                    r = wide[W-1:0];
                end
            end
            3'd4: r = {{(W-1){1'b0}}, lt};
            3'd5: r = fa ~^ fb;
            3'd6: r = {{(W-1){1'b0}}, ~^fa};
            default: begin
                wide = ax * bx;
                r = wide[W-1:0];
                o = fs ? (wide[c_iw-1:W-1] != {(W+1){wide[W-1]}}) : (|wide[c_iw-1:W]);
            end
        endcase
        return {o, r};
    endfunction

    logic [LANES*W-1:0] w_y;
    logic [LANES-1:0]   w_ovf;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        localparam int c_lo = (LANES - 1 - l) * W;
        assign {w_ovf[LANES-1-l], w_y[c_lo +: W]} =
            eval_lane(a[c_lo +: W], b[c_lo +: W], op[(LANES-1-l)*3 +: 3], SIGNED_MASK[LANES-1-l]);
    end

    logic [PIPE-1:0]    r_v;
    logic [LANES*W-1:0] r_y   [PIPE];
    logic [LANES-1:0]   r_ovf [PIPE];
    logic [PIPE-1:0]    w_rdy;
    logic [15:0]        r_count;

    // Stage k can load unless it and every stage after it are full and the sink stalls.
    for (genvar k = 0; k < PIPE; k++) begin : g_rdy
        assign w_rdy[k] = out_ready || !(&r_v[PIPE-1:k]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_v <= '0;
            for (int k = 0; k < PIPE; k++) begin
                r_y[k]   <= '0;
                r_ovf[k] <= '0;
            end
        end else begin
            if (w_rdy[0]) begin
                r_v[0] <= in_valid;
                if (in_valid) begin
                    r_y[0]   <= w_y;
                    r_ovf[0] <= w_ovf;
                end
            end
            for (int k = 1; k < PIPE; k++) begin
                if (w_rdy[k]) begin
                    r_v[k] <= r_v[k-1];
                    if (r_v[k-1]) begin
                        r_y[k]   <= r_y[k-1];
                        r_ovf[k] <= r_ovf[k-1];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (r_v[PIPE-1] && out_ready) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign in_ready  = w_rdy[0];
    assign out_valid = r_v[PIPE-1];
    assign y         = r_y[PIPE-1];
    assign ovf       = r_ovf[PIPE-1];
    assign count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_expression_pipe_eval.sv
`default_nettype none
// ============================================================================
// tb_expression_pipe_eval
// Scoreboard bench: integer reference model per lane, queue of expected results.
// Rev 1.0
// ============================================================================
module tb_expression_pipe_eval;

    localparam logic [5:0] SM = 6'b000111;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [35:0] a;
    logic [35:0] b;
    logic [17:0] op;
    logic        out_valid;
    logic        out_ready;
    logic [35:0] y;
    logic [5:0]  ovf;
    logic [15:0] count;

    expression_pipe_eval #(.W(6), .LANES(6), .SIGNED_MASK(6'b000111), .PIPE(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .ovf(ovf), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [35:0] y;
        logic [5:0]  ovf;
        int          t;
    } sb_t;

    sb_t         sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    bit          lat_chk = 1'b0;
    logic [35:0] da, db;
    logic [17:0] dop;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [6:0] mlane(input logic [5:0] la, input logic [5:0] lb,
                                         input logic [2:0] lop, input bit s);
        int au, bu, av, bv, full;
        logic [5:0] r;
        bit o;
        au = int'(la);
        bu = int'(lb);
        if (s) begin av = $signed(la); bv = $signed(lb); end
        else   begin av = au;          bv = bu;          end
        full = 0;
        o = 1'b0;
        case (lop)
            3'd0: begin full = av + bv; o = s ? (full < -32 || full > 31) : (full > 63); end
            3'd1: begin full = av - bv; o = s ? (full < -32 || full > 31) : (full < 0); end
            3'd2: begin
                if (bu < 6) begin
                    full = au << bu;
                    o = s ? (full[5] != la[5]) : (full > 63);
                end
            end
            3'd3: begin
                if (bu >= 6) full = (s && la[5]) ? -1 : 0;
                else         full = s ? (av >>> bu) : (au >> bu);
            end
            3'd4: full = (av < bv) ? 1 : 0;
            3'd5: full = ~(au ^ bu);
            3'd6: full = ($countones(la) % 2 == 0) ? 1 : 0;
            default: begin full = av * bv; o = s ? (full < -32 || full > 31) : (full > 63); end
        endcase
        r = full[5:0];
        return {o, r};
    endfunction

    function automatic sb_t model(input logic [35:0] va, input logic [35:0] vb,
                                  input logic [17:0] vo, input int t);
        sb_t e;
        logic [6:0] r;
        for (int l = 0; l < 6; l++) begin
            r = mlane(va[(5-l)*6 +: 6], vb[(5-l)*6 +: 6], vo[(5-l)*3 +: 3], SM[5-l]);
            e.y[(5-l)*6 +: 6] = r[5:0];
            e.ovf[5-l]        = r[6];
        end
        e.t = t;
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Handshakes are observed mid-cycle, ahead of the edge that completes them.
    always @(negedge clk) begin
        sb_t e;
        if (reset) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_out", 64'(y), 64'hDEAD);
                end else begin
                    e = sb.pop_front();
                    check("y", 64'(y), 64'(e.y));
                    check("ovf", 64'(ovf), 64'(e.ovf));
                    if (lat_chk) check("latency", 64'(cyc - e.t), 64'd2);
                end
            end
            if (in_valid && in_ready) sb.push_back(model(a, b, op, cyc));
        end
    end

    task automatic put(input int lane, input logic [5:0] av, input logic [5:0] bv, input logic [2:0] ov);
        da[(5-lane)*6 +: 6] = av;
        db[(5-lane)*6 +: 6] = bv;
        dop[(5-lane)*3 +: 3] = ov;
    endtask

    task automatic send(input logic [35:0] va, input logic [35:0] vb, input logic [17:0] vo);
        int n;
        bit acc;
        n = 0;
        acc = 1'b0;
        a = va; b = vb; op = vo; in_valid = 1'b1;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) check("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic rand_item(output logic [35:0] va, output logic [35:0] vb, output logic [17:0] vo);
        for (int l = 0; l < 6; l++) begin
            va[l*6 +: 6] = 6'($urandom_range(0, 63));
            vb[l*6 +: 6] = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63));
        end
        vo = 18'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [35:0] ia [4];
        logic [35:0] ib [4];
        logic [17:0] io [4];
        logic [35:0] snap;
        bit          have_snap;
        bit          acc;
        int          idx;
        int          n;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; op = '0; da = '0; db = '0; dop = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_y", 64'(y), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Add/sub carries and signed overflow
        put(0, 6'd60, 6'd5, 3'd0);  put(1, 6'd5, 6'd9, 3'd5);  put(2, 6'd13, 6'd0, 3'd6);
        put(3, 6'd31, 6'd1, 3'd0);  put(4, 6'b100000, 6'd1, 3'd1); put(5, 6'd3, 6'd2, 3'd2);
        send(da, db, dop);
        // Shifts, including out-of-range amounts
        put(0, 6'd3, 6'd7, 3'd4);   put(1, 6'b111000, 6'd2, 3'd3); put(2, 6'd1, 6'd6, 3'd2);
        put(3, 6'b010000, 6'd1, 3'd2); put(4, 6'b111000, 6'd2, 3'd3); put(5, 6'b100000, 6'd7, 3'd3);
        send(da, db, dop);
        // Compares and multiplies
        put(0, 6'd9, 6'd8, 3'd7);   put(1, 6'b110000, 6'd2, 3'd2); put(2, 6'b111111, 6'd1, 3'd4);
        put(3, 6'b111101, 6'd5, 3'd7); put(4, 6'b100000, 6'b111111, 3'd7); put(5, 6'b111111, 6'd1, 3'd4);
        send(da, db, dop);
        drain();
        check("count_directed", 64'(count), 64'd3);

        // Backpressure: capacity, stability, ordering
        do_reset();
        for (int i = 0; i < 4; i++) rand_item(ia[i], ib[i], io[i]);
        out_ready = 1'b0;
        idx = 0; have_snap = 1'b0;
        a = ia[0]; b = ib[0]; op = io[0]; in_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            acc = in_ready;
            if (out_valid) begin
                if (have_snap) check("stall_y_stable", 64'(y), 64'(snap));
                else begin snap = y; have_snap = 1'b1; end
            end
            @(posedge clk);
            #1;
            if (acc) begin
                idx++;
                if (idx < 4) begin a = ia[idx]; b = ib[idx]; op = io[idx]; end
            end
        end
        check("stall_accepted", 64'(idx), 64'd2);
        @(negedge clk);
        check("stall_in_ready", 64'(in_ready), 64'd0);
        check("stall_out_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        n = 0;
        while (idx < 4 && n < 20) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
            if (acc) begin
                idx++;
                if (idx < 4) begin a = ia[idx]; b = ib[idx]; op = io[idx]; end
            end
        end
        in_valid = 1'b0;
        check("release_accepted", 64'(idx), 64'd4);
        drain();
        check("count_stall", 64'(count), 64'd4);

        // Streaming at full rate with latency check
        do_reset();
        lat_chk = 1'b1;
        for (int i = 0; i < 100; i++) begin
            rand_item(da, db, dop);
            send(da, db, dop);
        end
        drain();
        lat_chk = 1'b0;
        check("count_stream", 64'(count), 64'd100);

        // Reset with two items in flight
        rand_item(da, db, dop); send(da, db, dop);
        rand_item(da, db, dop); send(da, db, dop);
        reset = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_y", 64'(y), 64'd0);
        check("mid_rst_count", 64'(count), 64'd0);
        @(posedge clk);
        #1;
        rand_item(da, db, dop);
        send(da, db, dop);
        drain();
        check("count_after_rst", 64'(count), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
